// File: rtl/cra.sv
// Registered WIDTH-bit ripple-carry adder: 1-cycle latency, one add per cycle, no backpressure.
// Optional signed-overflow flag output ovf is built when CRA_OVERFLOW_EN is defined.
module cra #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cIn,
  output logic             out_valid,
`ifdef CRA_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic [WIDTH:0]   sum
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_s;

  logic [WIDTH:0]   r_sum;
  logic             r_vld;

  // Explicit bit-serial carry ripple, one full-adder cell per bit.
  always_comb begin
    w_c    = '0;
    w_p    = '0;
    w_s    = '0;
    w_c[0] = cIn;
    for (int i = 0; i < WIDTH; i++) begin
      w_p[i]   = A[i] ^ B[i];
      w_s[i]   = w_p[i] ^ w_c[i];
      w_c[i+1] = (A[i] & B[i]) | (w_c[i] & w_p[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= in_valid;
      if (in_valid) begin
        r_sum <= {w_c[WIDTH], w_s};
      end
    end
  end

  assign sum       = r_sum;
  assign out_valid = r_vld;

`ifdef CRA_OVERFLOW_EN
  logic r_ovf;

  // Two's-complement overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (in_valid) begin
      r_ovf <= w_c[WIDTH] ^ w_c[WIDTH-1];
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_cra.sv
// Scoreboard bench for cra: driver pushes expected per-cycle outputs, monitor pops and compares.
module tb_cra;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic       cIn;
  logic       out_valid;
  logic [8:0] sum;
`ifdef CRA_OVERFLOW_EN
  logic       ovf;
`endif

  cra #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .cIn       (cIn),
    .out_valid (out_valid),
`ifdef CRA_OVERFLOW_EN
    .ovf       (ovf),
`endif
    .sum       (sum)
  );

  typedef struct {
    bit       v;
    bit [8:0] s;
    bit       o;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned last_sum;
  bit          last_ovf;
  int          n_checks;
  int          n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic bit signed_ovf(input int a, input int b, input int c);
    int sa;
    int sb;
    int r;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    r  = sa + sb + c;
    return (r > 127) || (r < -128);
  endfunction

  task automatic drive(input bit rst, input bit v, input int a, input int b, input int c);
    exp_t e;
    @(negedge clk);
    rst_n    = rst;
    in_valid = v;
    A        = a[7:0];
    B        = b[7:0];
    cIn      = c[0];
    if (!rst) begin
      last_sum = 0;
      last_ovf = 1'b0;
      e.v      = 1'b0;
    end else begin
      e.v = v;
      if (v) begin
        last_sum = a + b + c;
        last_ovf = signed_ovf(a, b, c);
      end
    end
    e.s = last_sum[8:0];
    e.o = last_ovf;
    exp_q.push_back(e);
  endtask

  // Monitor: one expected entry per driven cycle, compared just after the edge that consumes it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_valid", out_valid, e.v);
        check("sum", sum, e.s);
`ifdef CRA_OVERFLOW_EN
        check("ovf", ovf, e.o);
`endif
      end
    end
  end

  initial begin
    int a;
    int b;
    int c;
    n_checks = 0;
    n_pass   = 0;
    last_sum = 0;
    last_ovf = 1'b0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    A        = 8'd255;
    B        = 8'd255;
    cIn      = 1'b1;

    #1;
    check("reset_sum", sum, 0);
    check("reset_vld", out_valid, 0);

    repeat (3) drive(1'b0, 1'b1, 255, 255, 1);

    drive(1'b1, 1'b1, 255, 122, 0);
    drive(1'b1, 1'b1, 12, 124, 0);
    drive(1'b1, 1'b1, 3, 10, 0);
    drive(1'b1, 1'b1, 200, 30, 0);
    drive(1'b1, 1'b1, 23, 100, 0);

    drive(1'b1, 1'b1, 0, 0, 1);
    drive(1'b1, 1'b1, 255, 255, 1);
    drive(1'b1, 1'b1, 255, 0, 1);

    drive(1'b1, 1'b1, 12, 124, 0);
    repeat (3) drive(1'b1, 1'b0, 3, 10, 0);

    drive(1'b1, 1'b1, 127, 1, 0);
    drive(1'b1, 1'b1, 128, 128, 0);
    drive(1'b1, 1'b1, 255, 1, 0);
    drive(1'b1, 1'b1, 128, 255, 0);

    // Asynchronous reset between edges must clear outputs without waiting for a clock.
    drive(1'b1, 1'b1, 200, 100, 1);
    @(posedge clk);
    #3;
    rst_n    = 1'b0;
    last_sum = 0;
    last_ovf = 1'b0;
    #1;
    check("async_rst_sum", sum, 0);
    check("async_rst_vld", out_valid, 0);
    drive(1'b0, 1'b1, 255, 255, 1);
    drive(1'b0, 1'b1, 255, 255, 1);
    drive(1'b1, 1'b1, 1, 2, 1);

    for (int i = 0; i < 10000; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      c = $urandom_range(0, 1);
      drive(1'b1, $urandom_range(0, 1) != 0, a, b, c);
    end
    drive(1'b1, 1'b0, 0, 0, 0);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cra.md
# cra

Registered 8-bit ripple-carry adder: adds two unsigned operands plus a carry-in through a chain of full-adder cells and registers the 9-bit result. It is the ripple-carry reference arithmetic block, used as the baseline against carry-lookahead adders and as a general-purpose registered adder in datapaths. The carry chain is an explicit bit-serial ripple, not a synthesis `+` operator, so that the carry-propagation structure is preserved.

## Interface
- WIDTH, 8, operand width in bits; sum is WIDTH+1 bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands on A/B/cIn are valid this cycle.
- A  input  WIDTH  unsigned operand A.
- B  input  WIDTH  unsigned operand B.
- cIn  input  1  carry-in.
- out_valid  output  1  sum holds a result computed from a valid input.
- sum  output  WIDTH+1  registered result; MSB is carry-out.
- ovf  output  1  signed overflow flag; present only with CRA_OVERFLOW_EN.

## Operation
- Combinational core: WIDTH full-adder cells; cell i: s[i] = A[i]^B[i]^c[i], c[i+1] = A[i]&B[i] | c[i]&(A[i]^B[i]); c[0] = cIn.
- Result = {c[WIDTH], s[WIDTH-1:0]} = A + B + cIn, exact, no truncation; range 0 to 2^(WIDTH+1)-1 (511 for WIDTH=8).
- sum register loads the result on every rising clk where in_valid=1; holds its value when in_valid=0.
- out_valid register loads in_valid on every rising clk.
- Operands are unsigned; no saturation, no wrap (the 9th bit captures the carry).
- Operand changes when in_valid=0 do not affect sum.

## Timing
- Latency 1 cycle: result for operands sampled at edge N is on sum at edge N (visible after clk-to-q), out_valid=1 in the same cycle.
- Throughput: one addition per cycle, back-to-back in_valid allowed.
- Reset (rst_n=0, asynchronous, any time): sum=0, out_valid=0, ovf=0 immediately; held while rst_n=0.
- First valid load after reset release occurs on the first rising clk with rst_n=1 and in_valid=1.
- Reset asserted mid-stream discards the in-flight result; no partial outputs.
- Critical path: WIDTH-stage carry ripple from A[0]/B[0]/cIn to c[WIDTH]; must close within one clock period.

## Configuration
- CRA_OVERFLOW_EN defined: adds output ovf, registered alongside sum (same enable, same reset), ovf = c[WIDTH] ^ c[WIDTH-1] (two's-complement overflow of the WIDTH-bit sum).
- CRA_OVERFLOW_EN undefined: port ovf and its register do not exist; all other behaviour identical.

## Test plan
- Reset: hold rst_n=0 with A=255,B=255,cIn=1,in_valid=1 and toggle clk -> sum=0, out_valid=0 throughout; assert rst_n low asynchronously between edges -> outputs clear immediately.
- Directed vectors, cIn=0, in_valid=1, one per cycle: (255,122)->377, (12,124)->136, (3,10)->13, (200,30)->230, (23,100)->123, each on sum one edge after being applied, out_valid=1.
- Carry-in and extremes: (0,0,cIn=1)->1; (255,255,cIn=1)->511; (255,0,cIn=1)->256 (full carry ripple through all 8 cells).
- Hold: load (12,124)->136, then in_valid=0 with A=3,B=10 for 3 cycles -> sum stays 136, out_valid=0.
- Overflow (CRA_OVERFLOW_EN): (127,1,0)->sum 128, ovf=1; (128,128,0)->sum 256, ovf=1; (255,1,0)->sum 256, ovf=0.
- Random: 10,000 random A/B/cIn with random in_valid -> sum equals A+B+cIn of the last valid sample, compared against a reference model every cycle.
